// File: rtl/frigate_xo_startup_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// frigate_xo_startup_ctrl
//
// Start-up sequencer for the low/high-speed crystal oscillator. It brings the
// oscillator through bias settling and start-up, then watches it for loss of
// clock. Any start-up timeout or loss of clock parks the block in FAIL until
// the request is withdrawn.
//
// Parameters
//   SETTLE_CYC  : bias-settle time in clk cycles (ena=1, standby=1)
//   EDGE_CNT    : xo_dout rising edges needed to declare the crystal started
//   TIMEOUT_CYC : maximum clk cycles allowed in START
//   LOSS_CYC    : maximum clk cycles without an xo_dout edge while in RUN
//   CNT_W       : width of every internal counter
//
// Ports
//   clk        in   single clock (16 MHz R-C oscillator)
//   resetb     in   synchronous active-low reset
//   req        in   level request to run the crystal oscillator
//   xo_dout    in   crystal oscillator digital output (asynchronous to clk)
//   xo_ena     out  oscillator enable
//   xo_standby out  oscillator standby
//   ready      out  crystal clock valid for downstream clock muxing
//   fail       out  start timeout or loss of clock; held until req drops
//   state      out  current FSM state encoding for status readback
// -----------------------------------------------------------------------------
module frigate_xo_startup_ctrl #(
   parameter int SETTLE_CYC  = 1024,
   parameter int EDGE_CNT    = 256,
   parameter int TIMEOUT_CYC = 65535,
   parameter int LOSS_CYC    = 64,
   parameter int CNT_W       = 16
) (
   input  logic       clk,
   input  logic       resetb,
   input  logic       req,
   input  logic       xo_dout,
   output logic       xo_ena,
   output logic       xo_standby,
   output logic       ready,
   output logic       fail,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_START  = 3'd2,
      ST_RUN    = 3'd3,
      ST_FAIL   = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] LOSS_LAST    = CNT_W'(LOSS_CYC - 1);
   localparam logic [CNT_W-1:0] EDGE_TARGET  = CNT_W'(EDGE_CNT);

   state_t           state_reg;
   state_t           state_next;
   logic [CNT_W-1:0] timer_reg;
   logic [CNT_W-1:0] timer_next;
   logic [CNT_W-1:0] edge_cnt_reg;
   logic [CNT_W-1:0] edge_cnt_next;
   logic [CNT_W-1:0] edge_cnt_inc;
   // [0] and [1] form the synchronizer, [2] is the delayed copy for edge detect
   logic [2:0]       sync_reg;
   logic             edge_pulse;

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
      return (val == {CNT_W{1'b1}}) ? val : val + 1'b1;
   endfunction

   // One-cycle pulse per synchronized rising edge of xo_dout.
   assign edge_pulse = sync_reg[1] & ~sync_reg[2];

   assign state = state_reg;

   // Next-state and counter logic. Every branch that changes state leaves the
   // counters at their cleared defaults.
   always_comb begin
      state_next    = ST_IDLE;
      timer_next    = '0;
      edge_cnt_next = '0;
      edge_cnt_inc  = edge_pulse ? sat_inc(edge_cnt_reg) : edge_cnt_reg;

      if (!req) begin
         state_next = ST_IDLE;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
               if (timer_reg == SETTLE_LAST) begin
                  state_next = ST_START;
               end else begin
                  state_next = ST_SETTLE;
                  timer_next = sat_inc(timer_reg);
               end
            end
            ST_START: begin
               // Success is tested first so it wins over a coincident timeout.
               if (edge_cnt_inc >= EDGE_TARGET) begin
                  state_next = ST_RUN;
               end else if (timer_reg == TIMEOUT_LAST) begin
                  state_next = ST_FAIL;
               end else begin
                  state_next    = ST_START;
                  timer_next    = sat_inc(timer_reg);
                  edge_cnt_next = edge_cnt_inc;
               end
            end
            ST_RUN: begin
               // timer_reg is the loss-of-clock timer here.
               if (edge_pulse) begin
                  state_next = ST_RUN;
               end else if (timer_reg == LOSS_LAST) begin
                  state_next = ST_FAIL;
               end else begin
                  state_next = ST_RUN;
                  timer_next = sat_inc(timer_reg);
               end
            end
            ST_FAIL: begin
               state_next = ST_FAIL;
            end
            default: begin
               state_next = ST_IDLE;
            end
         endcase
      end
   end

   // State, counters, synchronizer and outputs. Outputs are decoded from the
   // next state so that each registered output lines up with state_reg.
   always_ff @(posedge clk) begin
      if (!resetb) begin
         state_reg    <= ST_IDLE;
         timer_reg    <= '0;
         edge_cnt_reg <= '0;
         sync_reg     <= '0;
         xo_ena       <= 1'b0;
         xo_standby   <= 1'b1;
         ready        <= 1'b0;
         fail         <= 1'b0;
      end else begin
         sync_reg     <= {sync_reg[1:0], xo_dout};
         state_reg    <= state_next;
         timer_reg    <= timer_next;
         edge_cnt_reg <= edge_cnt_next;
         xo_ena       <= (state_next == ST_SETTLE) || (state_next == ST_START) ||
                         (state_next == ST_RUN);
         xo_standby   <= (state_next == ST_IDLE) || (state_next == ST_SETTLE) ||
                         (state_next == ST_FAIL);
         ready        <= (state_next == ST_RUN);
         fail         <= (state_next == ST_FAIL);
      end
   end

endmodule

// File: tb/tb_frigate_xo_startup_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_frigate_xo_startup_ctrl
//
// Drives directed start-up scenarios followed by a randomized phase, and checks
// the block every cycle against a behavioural reference model. The model keeps
// a short history of sampled xo_dout values and applies the start-up rules
// with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_frigate_xo_startup_ctrl;

   localparam int SETTLE_CYC  = 8;
   localparam int EDGE_CNT    = 4;
   localparam int TIMEOUT_CYC = 100;
   localparam int LOSS_CYC    = 16;
   localparam int CNT_W       = 16;

   localparam int S_IDLE   = 0;
   localparam int S_SETTLE = 1;
   localparam int S_START  = 2;
   localparam int S_RUN    = 3;
   localparam int S_FAIL   = 4;

   localparam int M_HOLD0 = 0;   // xo_dout held low
   localparam int M_NOM   = 1;   // toggle every 6 clk from START entry
   localparam int M_SIM   = 2;   // 4th edge lands on the last START cycle
   localparam int M_RAND  = 3;   // randomized req / reset / xo_dout

   logic       clk = 1'b0;
   logic       resetb = 1'b0;
   logic       req = 1'b0;
   logic       xo_dout = 1'b0;
   logic       xo_ena;
   logic       xo_standby;
   logic       ready;
   logic       fail;
   logic [2:0] state;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int mode = M_HOLD0;

   // reference model
   int       m_st = S_IDLE;
   int       m_tmr = 0;
   int       m_ec = 0;
   int       m_start_edge = 0;
   int       m_last_pulse = 0;
   bit [2:0] m_smp = '0;   // [0] = sample from the previous edge

   int enter[8];
   int prev_state = 0;
   int rand_period = 5;
   bit rand_run = 1'b1;

   always #5 clk = ~clk;

   frigate_xo_startup_ctrl #(
      .SETTLE_CYC (SETTLE_CYC),
      .EDGE_CNT   (EDGE_CNT),
      .TIMEOUT_CYC(TIMEOUT_CYC),
      .LOSS_CYC   (LOSS_CYC),
      .CNT_W      (CNT_W)
   ) dut (
      .clk       (clk),
      .resetb    (resetb),
      .req       (req),
      .xo_dout   (xo_dout),
      .xo_ena    (xo_ena),
      .xo_standby(xo_standby),
      .ready     (ready),
      .fail      (fail),
      .state     (state)
   );

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // {xo_ena, xo_standby, ready, fail} for each state
   function automatic int exp_outs(input int st);
      case (st)
         S_IDLE:   return 4'b0100;
         S_SETTLE: return 4'b1100;
         S_START:  return 4'b1000;
         S_RUN:    return 4'b1010;
         S_FAIL:   return 4'b0101;
         default:  return 0;
      endcase
   endfunction

   function automatic void m_goto(input int st);
      m_st  = st;
      m_tmr = 0;
      m_ec  = 0;
      if (st == S_START) m_start_edge = cyc;
   endfunction

   // One clock edge of the reference model. A rising transition sampled at
   // edge n is acted on at edge n+2.
   function automatic void model_step(input bit rb, input bit r, input bit x);
      int pulse;
      pulse = (m_smp[1] && !m_smp[2]) ? 1 : 0;
      if (!rb) begin
         m_goto(S_IDLE);
         m_smp = '0;
         return;
      end
      m_smp = {m_smp[1:0], x};
      if (pulse == 1) m_last_pulse = cyc;
      if (!r) begin
         m_goto(S_IDLE);
         return;
      end
      case (m_st)
         S_IDLE:   m_goto(S_SETTLE);
         S_SETTLE: if (m_tmr == SETTLE_CYC - 1) m_goto(S_START); else m_tmr++;
         S_START: begin
            if (m_ec + pulse >= EDGE_CNT) m_goto(S_RUN);
            else if (m_tmr == TIMEOUT_CYC - 1) m_goto(S_FAIL);
            else begin
               m_tmr++;
               m_ec += pulse;
            end
         end
         S_RUN: begin
            if (pulse == 1) m_tmr = 0;
            else if (m_tmr == LOSS_CYC - 1) m_goto(S_FAIL);
            else m_tmr++;
         end
         S_FAIL:   ;
         default:  m_goto(S_IDLE);
      endcase
   endfunction

   // Sets the inputs for the upcoming clock edge.
   task automatic drive();
      int k;
      k = cyc + 1 - m_start_edge;
      case (mode)
         M_NOM: begin
            if (m_st == S_SETTLE)
               // toggle while settling, quiet for the last three settle cycles
               xo_dout = (m_tmr < SETTLE_CYC - 3) ? ((cyc / 2) % 2 == 1) : 1'b0;
            else if (m_st == S_START || m_st == S_RUN)
               xo_dout = ((k / 6) % 2 == 1);
            else
               xo_dout = 1'b0;
         end
         M_SIM: begin
            xo_dout = (m_st == S_START) && (k == 2 || k == 10 || k == 20 || k == 98);
         end
         M_RAND: begin
            resetb = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 79) == 0) req = ~req;
            if ($urandom_range(0, 199) == 0) rand_run = ~rand_run;
            if ($urandom_range(0, 399) == 0) rand_period = $urandom_range(1, 20);
            xo_dout = rand_run ? ((cyc / rand_period) % 2 == 1) : 1'b0;
            if ($urandom_range(0, 15) == 0) xo_dout = ($urandom_range(0, 1) == 1);
         end
         default: xo_dout = 1'b0;
      endcase
   endtask

   task automatic do_cycle();
      @(negedge clk);
      drive();
      @(posedge clk);
      cyc++;
      model_step(resetb, req, xo_dout);
      #1;
      check("state", int'(state), m_st);
      check("outs", int'({xo_ena, xo_standby, ready, fail}), exp_outs(m_st));
      if (int'(state) != prev_state) begin
         enter[state] = cyc;
         prev_state = int'(state);
      end
   endtask

   task automatic run_n(input int n);
      repeat (n) do_cycle();
   endtask

   task automatic run_until(input string tag, input int st, input int bound);
      int n;
      n = 0;
      while (int'(state) != st && n < bound) begin
         do_cycle();
         n++;
      end
      check(tag, int'(state), st);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) enter[i] = -1;

      $display("scenario reset");
      resetb = 1'b0; req = 1'b0; mode = M_HOLD0;
      run_n(3);
      check("rst_outs", int'({xo_ena, xo_standby, ready, fail, state}), 7'b0100000);
      resetb = 1'b1;
      run_n(2);
      check("idle_hold", int'(state), S_IDLE);

      $display("scenario nominal start");
      mode = M_NOM; req = 1'b1;
      run_until("nom_run", S_RUN, 300);
      check("nom_settle_len", enter[S_START] - enter[S_SETTLE], SETTLE_CYC);
      check("nom_start_len", enter[S_RUN] - enter[S_START], 44);
      check("nom_ready", int'(ready), 1);

      $display("scenario loss of clock");
      run_n(30);
      check("run_kept", int'(state), S_RUN);
      mode = M_HOLD0;
      run_until("loss_fail", S_FAIL, 100);
      check("loss_len", enter[S_FAIL] - m_last_pulse, LOSS_CYC);
      check("loss_ready", int'(ready), 0);
      run_n(5);
      check("loss_sticky", int'(fail), 1);
      req = 1'b0;
      run_n(1);
      check("loss_idle", int'(state), S_IDLE);

      $display("scenario start timeout");
      mode = M_HOLD0; req = 1'b1;
      run_until("to_fail", S_FAIL, 300);
      check("to_len", enter[S_FAIL] - enter[S_START], TIMEOUT_CYC);
      check("to_ena", int'(xo_ena), 0);
      check("to_flag", int'(fail), 1);
      run_n(10);
      check("to_sticky", int'(fail), 1);
      req = 1'b0;
      run_n(1);
      check("to_idle", int'(state), S_IDLE);
      check("to_fail_drop", int'(fail), 0);

      $display("scenario success on last start cycle");
      mode = M_SIM; req = 1'b1;
      run_until("sim_run", S_RUN, 300);
      check("sim_len", enter[S_RUN] - enter[S_START], TIMEOUT_CYC);
      req = 1'b0;
      run_n(1);

      $display("scenario req drop in settle, edges during settle");
      mode = M_NOM; req = 1'b1;
      run_until("drop_settle", S_SETTLE, 5);
      run_n(3);
      req = 1'b0;
      run_n(1);
      check("drop_idle", int'(state), S_IDLE);
      req = 1'b1;
      run_until("drop_start", S_START, 50);
      check("drop_settle_len", enter[S_START] - enter[S_SETTLE], SETTLE_CYC);
      run_until("tog_run", S_RUN, 200);
      check("tog_start_len", enter[S_RUN] - enter[S_START], 44);

      $display("scenario reset in run");
      resetb = 1'b0;
      run_n(1);
      check("rst_in_run", int'({xo_ena, xo_standby, ready, fail, state}), 7'b0100000);
      resetb = 1'b1;

      $display("scenario randomized");
      mode = M_RAND; req = 1'b1;
      run_n(4000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
